// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int DEFAULT_N = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width holding addresses 0..n*n-1, never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/matmul_lat_pipe.sv
// Fixed-depth shift register that tracks issued beats until the MAC result is ready.
module matmul_lat_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
    end else begin
      stage[0] <= din;
      for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for the single-MAC matmul datapath: walks i/j/k, issues A/B reads,
// and emits C write strobes once the accumulated result leaves the latency pipe.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int PIPE_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         hold,
  output logic                         rd_en,
  output logic [addr_width(N)-1:0]     a_addr,
  output logic [addr_width(N)-1:0]     b_addr,
  output logic                         acc_first,
  output logic                         c_we,
  output logic [addr_width(N)-1:0]     c_addr,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = addr_width(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [AW-1:0] MAXA = AW'(N * N - 1);

  state_t state, state_d;

  // i/j/k name the next beat to issue; they move only when a beat is issued.
  logic [AW-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
  logic [AW-1:0] a_addr_d, b_addr_d, iss_addr_q, iss_addr_d;
  logic          rd_en_d, acc_first_d, last_k_q, last_k_d;
  logic          issue, last_beat, drain_exit;

  logic          pipe_v, pipe_l;
  logic [AW-1:0] pipe_a;

  assign last_beat  = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);
  assign c_we       = pipe_v & pipe_l;
  assign c_addr     = c_we ? pipe_a : '0;
  assign drain_exit = c_we && (pipe_a == MAXA);

  // Beat handshake: hold is sampled on the edge that would launch a beat.
  // hold=0 launches it (rd_en=1 next cycle, counters advance); hold=1 keeps
  // rd_en=0 and presents the still-pending beat's addresses unchanged.
  always_comb begin
    state_d     = state;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    a_addr_d    = a_addr;
    b_addr_d    = b_addr;
    iss_addr_d  = iss_addr_q;
    rd_en_d     = 1'b0;
    acc_first_d = 1'b0;
    last_k_d    = 1'b0;
    issue       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          issue   = 1'b1;
        end
      end
      RUN:     issue = 1'b1;
      DRAIN:   if (drain_exit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      a_addr_d   = AW'(int'(i_q) * N + int'(k_q));
      b_addr_d   = AW'(int'(k_q) * N + int'(j_q));
      iss_addr_d = AW'(int'(i_q) * N + int'(j_q));
      if (!hold) begin
        rd_en_d     = 1'b1;
        acc_first_d = (k_q == '0);
        last_k_d    = (k_q == LAST);
        if (k_q == LAST) begin
          k_d = '0;
          if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + AW'(1);
          end else begin
            j_d = j_q + AW'(1);
          end
        end else begin
          k_d = k_q + AW'(1);
        end
        if (last_beat) begin
          state_d = DRAIN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      rd_en      <= 1'b0;
      a_addr     <= '0;
      b_addr     <= '0;
      acc_first  <= 1'b0;
      last_k_q   <= 1'b0;
      iss_addr_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      rd_en      <= rd_en_d;
      a_addr     <= a_addr_d;
      b_addr     <= b_addr_d;
      acc_first  <= acc_first_d;
      last_k_q   <= last_k_d;
      iss_addr_q <= iss_addr_d;
      busy       <= (state_d == RUN) || (state_d == DRAIN);
      done       <= (state_d == DONE);
    end
  end

  matmul_lat_pipe #(
    .DEPTH (PIPE_LAT),
    .W     (AW + 2)
  ) u_lat_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_en, last_k_q, iss_addr_q}),
    .dout ({pipe_v, pipe_l, pipe_a})
  );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: three configurations checked cycle by cycle against a
// schedule model built from the beat order, the hold pattern and the pipe latency.
module tb_matmul_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, start_v, hold_v;
  logic [2:0] rd_v, af_v, we_v, busy_v, done_v;
  logic [1:0] a0, b0, c0;
  logic [0:0] a1, b1, c1;
  logic [3:0] a2, b2, c2;

  matmul_ctrl #(.N(2), .PIPE_LAT(2)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .hold(hold_v[0]),
    .rd_en(rd_v[0]), .a_addr(a0), .b_addr(b0), .acc_first(af_v[0]),
    .c_we(we_v[0]), .c_addr(c0), .busy(busy_v[0]), .done(done_v[0]));

  matmul_ctrl #(.N(1), .PIPE_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .hold(hold_v[1]),
    .rd_en(rd_v[1]), .a_addr(a1), .b_addr(b1), .acc_first(af_v[1]),
    .c_we(we_v[1]), .c_addr(c1), .busy(busy_v[1]), .done(done_v[1]));

  matmul_ctrl #(.N(3), .PIPE_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .hold(hold_v[2]),
    .rd_en(rd_v[2]), .a_addr(a2), .b_addr(b2), .acc_first(af_v[2]),
    .c_we(we_v[2]), .c_addr(c2), .busy(busy_v[2]), .done(done_v[2]));

  // ---------------- scoreboard state ----------------
  // Expected vector per cycle:
  // [29] addr valid, [28] rd_en, [27:20] a, [19:12] b, [11] acc_first,
  // [10] c_we, [9:2] c_addr, [1] busy, [0] done
  logic [29:0] exp_q[$];
  bit          hold_pat [256];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] obs_a(input int x);
    case (x)
      0:       return {6'd0, a0};
      1:       return {7'd0, a1};
      default: return {4'd0, a2};
    endcase
  endfunction

  function automatic logic [7:0] obs_b(input int x);
    case (x)
      0:       return {6'd0, b0};
      1:       return {7'd0, b1};
      default: return {4'd0, b2};
    endcase
  endfunction

  function automatic logic [7:0] obs_c(input int x);
    case (x)
      0:       return {6'd0, c0};
      1:       return {7'd0, c1};
      default: return {4'd0, c2};
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Beats in i,j,k order (k fastest); each non-hold cycle from cycle 1 takes the
  // next one. A k==N-1 beat writes C[i][j] lat cycles later; done follows the
  // final write; busy covers cycle 1 through the final write.
  task automatic build_exp(input int n, input int lat, output int dc);
    logic [29:0] tr [256];
    int idx, t, nb, last_we, bi, bj, bk;
    nb = n * n * n;
    for (int c = 0; c < 256; c++) tr[c] = '0;
    idx = 0;
    t   = 1;
    while (idx < nb) begin
      bi = idx / (n * n);
      bj = (idx / n) % n;
      bk = idx % n;
      tr[t][29]    = 1'b1;
      tr[t][27:20] = 8'(bi * n + bk);
      tr[t][19:12] = 8'(bk * n + bj);
      if (!hold_pat[t]) begin
        tr[t][28] = 1'b1;
        tr[t][11] = (bk == 0);
        if (bk == n - 1) begin
          tr[t+lat][10]  = 1'b1;
          tr[t+lat][9:2] = 8'(bi * n + bj);
        end
        idx++;
      end
      t++;
    end
    last_we = (t - 1) + lat;
    dc      = last_we + 1;
    for (int c = 1; c <= last_we; c++) tr[c][1] = 1'b1;
    tr[dc][0] = 1'b1;
    exp_q.delete();
    for (int c = 0; c <= dc; c++) exp_q.push_back(tr[c]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_hold();
    for (int c = 0; c < 256; c++) hold_pat[c] = 1'b0;
  endtask

  task automatic random_hold();
    for (int c = 0; c < 256; c++)
      hold_pat[c] = (c > 0 && c < 100) ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic compare_cycle(input int x, input int t, input logic [29:0] e);
    string p;
    p = $sformatf("u%0d cyc%0d", x, t);
    check({p, " rd_en"},     32'(rd_v[x]),   32'(e[28]));
    check({p, " acc_first"}, 32'(af_v[x]),   32'(e[11]));
    check({p, " c_we"},      32'(we_v[x]),   32'(e[10]));
    check({p, " busy"},      32'(busy_v[x]), 32'(e[1]));
    check({p, " done"},      32'(done_v[x]), 32'(e[0]));
    if (e[29]) begin
      check({p, " a_addr"}, 32'(obs_a(x)), 32'(e[27:20]));
      check({p, " b_addr"}, 32'(obs_b(x)), 32'(e[19:12]));
    end
    if (e[10]) check({p, " c_addr"}, 32'(obs_c(x)), 32'(e[9:2]));
  endtask

  task automatic check_quiet(input int x, input string tag);
    check({tag, " rd_en"}, 32'(rd_v[x]),   32'd0);
    check({tag, " c_we"},  32'(we_v[x]),   32'd0);
    check({tag, " busy"},  32'(busy_v[x]), 32'd0);
    check({tag, " done"},  32'(done_v[x]), 32'd0);
  endtask

  task automatic check_all_zero(input int x, input string tag);
    check_quiet(x, tag);
    check({tag, " acc_first"}, 32'(af_v[x]),    32'd0);
    check({tag, " a_addr"},    32'(obs_a(x)),   32'd0);
    check({tag, " b_addr"},    32'(obs_b(x)),   32'd0);
    check({tag, " c_addr"},    32'(obs_c(x)),   32'd0);
  endtask

  // Inputs for cycle t+1 are driven during cycle t, #1 after its rising edge,
  // so hold_pat[t] is the hold value seen by the edge that opens cycle t.
  task automatic run_case(input int x, input int n, input int lat,
                          input logic keep_start, input int abort_at);
    int dc;
    logic [29:0] e;
    build_exp(n, lat, dc);
    @(posedge clk); #1;
    start_v[x] = 1'b1;
    hold_v[x]  = hold_pat[1];
    for (int t = 0; t <= dc; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        start_v[x] = keep_start;
        hold_v[x]  = hold_pat[t+1];
      end
      e = exp_q.pop_front();
      compare_cycle(x, t, e);
      if (t == abort_at) begin
        rst_v[x] = 1'b0;
        break;
      end
    end
    hold_v[x] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_v   = '0;
    start_v = '0;
    hold_v  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int x = 0; x < 3; x++) check_all_zero(x, $sformatf("reset u%0d", x));
    rst_v = '1;

    clear_hold();
    run_case(0, 2, 2, 1'b0, -1);

    hold_pat[3] = 1'b1;
    hold_pat[4] = 1'b1;
    run_case(0, 2, 2, 1'b0, -1);

    clear_hold();
    run_case(0, 2, 2, 1'b0, 5);
    @(posedge clk); #1;
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b0;
    check_all_zero(0, "abort next cycle");
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check_quiet(0, $sformatf("after abort %0d", c));
    end
    run_case(0, 2, 2, 1'b0, -1);

    run_case(0, 2, 2, 1'b1, -1);
    run_case(0, 2, 2, 1'b0, -1);
    start_v[0] = 1'b0;

    run_case(1, 1, 1, 1'b0, -1);
    start_v[1] = 1'b0;

    hold_pat[1] = 1'b1;
    run_case(2, 3, 3, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      random_hold();
      run_case(2, 3, 3, 1'b0, -1);
    end
    start_v[2] = 1'b0;
    @(posedge clk); #1;
    for (int x = 0; x < 3; x++) check_quiet(x, $sformatf("final idle u%0d", x));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
- Sequencer for the single-MAC matrix-multiply datapath: computes C = A x B for N x N matrices held in A/B/C memories.
- On a start pulse, walks the i, j, k loops and issues one read/multiply-accumulate beat per cycle.
- Tracks datapath latency and emits C write strobes and addresses.
- Reports busy/done back to the top-level host.

Parameters:
- N, 3, matrix dimension (N >= 1)
- PIPE_LAT, 2, cycles from issue beat to product-accumulated at MAC output (>= 1)
- ADDR_WIDTH, clog2(N*N) (min 1), width of all memory addresses; derived localparam, not overridable

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- start  in  1  begin one multiplication; sampled only in IDLE
- hold  in  1  freeze issue counters (upstream not ready); pipeline keeps draining
- rd_en  out  1  issue beat valid: read A/B and MAC this cycle
- a_addr  out  ADDR_WIDTH  A address = i*N + k
- b_addr  out  ADDR_WIDTH  B address = k*N + j
- acc_first  out  1  beat is k==0; datapath loads product instead of accumulating
- c_we  out  1  C write strobe; accumulator holds final C[i][j]
- c_addr  out  ADDR_WIDTH  C address = i*N + j, aligned with c_we
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: one clock, single synchronous active-low reset (rst low at rising clk edge).
  - All outputs 0; state IDLE; i, j, k counters 0; latency pipe cleared.
  - Reset mid-operation aborts with no further rd_en or c_we.
- All outputs are registered.
- States:
  - IDLE: busy=0. start=1 -> RUN and first beat (0,0,0) on outputs next cycle; busy=1 from that cycle.
  - RUN: each cycle with hold=0 issues one beat (rd_en=1) and advances k, then j, then i (k fastest). With hold=1, rd_en=0, counters and addresses keep their values. After the beat i=j=k=N-1 -> DRAIN.
  - DRAIN: no beats issued; hold ignored. Wait until the latency pipe is empty and the final c_we has occurred -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- Beat order: k=0..N-1 for (0,0), then (0,1), ... up to (N-1,N-1). Exactly N^3 beats when hold is never asserted.
- Latency pipe: PIPE_LAT-deep shift register carrying {valid, last_k, c_addr}.
  - Entry is loaded from each issued beat; last_k = (k==N-1).
  - c_we = valid & last_k at the pipe output, PIPE_LAT cycles after the issue of k=N-1.
  - c_addr is presented with c_we.
- done asserts the cycle after the final c_we.
- Total cycles from start to done with hold=0: N^3 + PIPE_LAT + 1, counting start as cycle 0.
- Boundary conditions:
  - start while busy: ignored; start held high through DONE re-triggers only once back in IDLE.
  - N=1: every beat has acc_first=1 and last_k=1.
  - Counter wrap: k wraps to 0 with j increment; j wraps to 0 with i increment; i never wraps within a run.
  - Address arithmetic in ADDR_WIDTH bits; maximum value N*N-1, no overflow.
  - hold asserted on the very first RUN cycle: no beat issued; beat (0,0,0) waits.

Decomposition:
- Shared package matmul_pkg: state enum (IDLE/RUN/DRAIN/DONE), ADDR_WIDTH derivation function, default N.
- One sub-module: matmul_lat_pipe.
  - Parameterised shift register of depth PIPE_LAT and width ADDR_WIDTH+2.
  - Same clk/rst convention; valid bits cleared on reset.
- Counters and FSM stay in matmul_ctrl.

Test Plan (cycle 0 is the cycle start is sampled):
- N=2, PIPE_LAT=2, start pulse, hold=0.
  - rd_en in cycles 1-8.
  - (a_addr,b_addr) = (0,0),(1,2),(0,1),(1,3),(2,0),(3,2),(2,1),(3,3).
  - acc_first in cycles 1,3,5,7.
  - c_we in cycles 4,6,8,10 with c_addr 0,1,2,3.
  - done in cycle 11; busy high cycles 1-10.
- Same config, hold=1 in cycles 3-4.
  - Beats shift by 2; no rd_en in those cycles; addresses frozen at (0,1).
  - c_we in cycles 4,8,10,12; done in cycle 13.
- rst driven low in cycle 5 of a run.
  - All outputs 0 next cycle; no c_we afterwards.
  - A fresh start then completes normally.
- start held high continuously.
  - Exactly one run per IDLE visit.
  - Second run's first rd_en comes 2 cycles after done: IDLE cycle samples start, then the beat.
- N=1, PIPE_LAT=1.
  - Single beat in cycle 1 with acc_first=1.
  - c_we, c_addr=0 in cycle 2; done in cycle 3.
- N=3, PIPE_LAT=3, random hold.
  - Scoreboard checks all 27 beats in order and 9 c_we with c_addr 0..8 ascending.
  - Exactly one done pulse.
